// File: rtl/sram_in_ctrl_if.sv
// sram_in_ctrl_if: write-requester, read-burst and SRAM-pin bundle for sram_in_ctrl.
interface sram_in_ctrl_if #(parameter int AW = 7, parameter int DW = 32, parameter int LW = 8);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_start;
    logic [AW-1:0] rd_base;
    logic [LW-1:0] rd_len;
    logic          rd_busy;
    logic          rd_done;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;
    logic          par_err;
    logic          sram_csb0;
    logic          sram_web0;
    logic          sram_spare_wen0;
    logic [AW:0]   sram_addr0;
    logic [DW:0]   sram_din0;
    logic [DW:0]   sram_dout0;
    modport master (
        output wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len, sram_dout0,
        input  wr_ready, rd_busy, rd_done, rd_rvalid, rd_rdata, par_err,
        input  sram_csb0, sram_web0, sram_spare_wen0, sram_addr0, sram_din0
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len, sram_dout0,
        output wr_ready, rd_busy, rd_done, rd_rvalid, rd_rdata, par_err,
        output sram_csb0, sram_web0, sram_spare_wen0, sram_addr0, sram_din0
    );
endinterface

// File: rtl/sram_in_ctrl.sv
// sram_in_ctrl: round-robin write/read-burst arbiter in front of a 1-cycle synchronous SRAM.
// Define SRAM_IN_CTRL_PARITY_EN to store and check even parity in the spare bit.
module sram_in_ctrl #(parameter int AW = 7, parameter int DW = 32, parameter int LW = 8) (
    input logic        clk0,
    input logic        rst0,
    sram_in_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam logic [LW-1:0] MAX_BEATS = LW'(2 ** AW);
`ifdef SRAM_IN_CTRL_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    state_t        state, state_nx;
    logic          rst_d, blk, rd_req, wr_win, rd_win, rr_wr, z_start;
    logic          v1, v2, l1, l2, par_w, par_r;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] left_q;
    // grants are held off during reset and the cycle after it
    assign blk     = rst0 | rst_d;
    assign z_start = state == IDLE && bus.rd_start && bus.rd_len == '0;
    assign wr_win  = bus.wr_valid && !blk && (!rd_req || rr_wr);
    assign rd_win  = rd_req && !wr_win;
    assign par_w   = PAR_ON & ^bus.wr_data;
    assign par_r   = PAR_ON & ^bus.sram_dout0;
    assign bus.wr_ready = wr_win;
    always_ff @(posedge clk0) state <= rst0 ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (bus.rd_start && bus.rd_len != '0) ? ISSUE : IDLE;
            ISSUE:   state_nx = (rd_win && left_q == LW'(1)) ? DRAIN : ISSUE;
            DRAIN:   state_nx = bus.rd_done ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        rd_req      = state == ISSUE && !blk;
        bus.rd_busy = state != IDLE;
    end
    always_ff @(posedge clk0) begin
        if (rst0) begin
            rst_d               <= 1'b1;
            rr_wr               <= 1'b1;
            addr_q              <= '0;
            left_q              <= '0;
            {v1, v2, l1, l2}    <= '0;
            bus.rd_rvalid       <= 1'b0;
            bus.rd_done         <= 1'b0;
            bus.rd_rdata        <= '0;
            bus.par_err         <= 1'b0;
            bus.sram_csb0       <= 1'b1;
            bus.sram_web0       <= 1'b1;
            bus.sram_spare_wen0 <= 1'b0;
            bus.sram_addr0      <= '0;
            bus.sram_din0       <= '0;
        end else begin
            rst_d <= 1'b0;
            if (rd_req && bus.wr_valid) rr_wr <= !rr_wr;
            if (state == IDLE && bus.rd_start) begin
                addr_q <= bus.rd_base;
                left_q <= (bus.rd_len > MAX_BEATS) ? MAX_BEATS : bus.rd_len;
            end else if (rd_win) begin
                addr_q <= addr_q + AW'(1);
                left_q <= left_q - LW'(1);
            end
            // beat-valid and last-beat flags follow the SRAM's read pipeline
            v1            <= rd_win;
            l1            <= rd_win && left_q == LW'(1);
            v2            <= v1;
            l2            <= l1;
            bus.rd_rvalid <= v2;
            bus.rd_done   <= (v2 && l2) || z_start;
            bus.par_err   <= v2 && par_r;
            if (v2) bus.rd_rdata <= bus.sram_dout0[DW-1:0];
            bus.sram_csb0       <= !(wr_win || rd_win);
            bus.sram_web0       <= !wr_win;
            bus.sram_spare_wen0 <= PAR_ON && wr_win;
            if (wr_win || rd_win) bus.sram_addr0 <= {1'b0, wr_win ? bus.wr_addr : addr_q};
            if (wr_win) bus.sram_din0 <= {par_w, bus.wr_data};
        end
    end
endmodule

// File: tb/tb_sram_in_ctrl.sv
// tb_sram_in_ctrl: burst vector table, hand-written corner sequences and random traffic,
// all checked cycle by cycle against a transaction-level model with an SRAM behavioural model.
module tb_sram_in_ctrl;
    localparam int AW = 7, DW = 32, LW = 8;
`ifdef SRAM_IN_CTRL_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    logic clk0 = 1'b0;
    logic rst0 = 1'b1;
    logic flip = 1'b0;
    sram_in_ctrl_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();
    sram_in_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (.clk0(clk0), .rst0(rst0), .bus(bus));
    always #5 clk0 = ~clk0;

    logic [DW:0] mem [256] = '{default: '0};
    always @(posedge clk0) begin
        if (!bus.sram_csb0 && !bus.sram_web0)
            mem[bus.sram_addr0] <= {bus.sram_spare_wen0 ? bus.sram_din0[DW] : mem[bus.sram_addr0][DW], bus.sram_din0[DW-1:0]};
        else if (!bus.sram_csb0)
            bus.sram_dout0 <= mem[bus.sram_addr0] ^ {flip, {DW{1'b0}}};
    end

    typedef struct {int due; logic [DW-1:0] d; bit last; bit par;} beat_t;
    typedef struct {string name; bit wr_first; logic [AW-1:0] waddr; logic [DW-1:0] wdata; bit wr_hold;
                    logic [AW-1:0] base; logic [LW-1:0] len; int beats; int lat; logic [DW-1:0] d0;} vec_t;
    beat_t         exp_q[$];
    logic [DW-1:0] ref_mem [128] = '{default: '0};
    int            n_chk = 0, n_fail = 0, cyc = 0, o_cyc = 0, m_left = 0, m_addr = 0, prev_g = 0;
    bit            m_rr_wr = 1, m_busy = 0, m_zdone = 0, after_rst = 0, prev_rst = 0;
    bit            o_rv, o_done, o_par, o_spare;
    logic [DW-1:0] o_rdata, prev_data;
    logic [DW:0]   o_din;
    logic [AW-1:0] prev_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset();
        check("reset_ctrl", {bus.sram_csb0, bus.sram_web0, bus.sram_spare_wen0, bus.wr_ready,
                             bus.rd_busy, bus.rd_done, bus.rd_rvalid, bus.par_err}, 64'hC0);
        check("reset_pins", {bus.sram_addr0, bus.sram_din0}, '0);
        check("reset_rdata", bus.rd_rdata, '0);
    endtask

    // one clock cycle: inputs already applied; compare at negedge, advance the model
    task automatic step();
        bit exp_rv, exp_done, exp_par, exp_wr, rd_pend, rd_g;
        logic [DW-1:0] exp_d;
        beat_t b;
        @(negedge clk0);
        o_cyc = cyc; o_rv = bus.rd_rvalid; o_done = bus.rd_done; o_rdata = bus.rd_rdata;
        o_par = bus.par_err; o_din = bus.sram_din0; o_spare = bus.sram_spare_wen0;
        if (rst0) begin
            check("wr_ready_in_reset", bus.wr_ready, 0);
            if (prev_rst) check_reset();
            exp_q.delete();
            m_left = 0; m_busy = 0; m_zdone = 0; m_rr_wr = 1; prev_g = 0; after_rst = 1; prev_rst = 1;
        end else begin
            if (after_rst) check_reset();
            check("sram_csb0", bus.sram_csb0, prev_g == 0);
            check("sram_web0", bus.sram_web0, prev_g != 1);
            check("sram_spare_wen0", bus.sram_spare_wen0, PAR_ON && prev_g == 1);
            if (prev_g != 0) check("sram_addr0", bus.sram_addr0, {1'b0, prev_addr});
            if (prev_g == 1) check("sram_din0", bus.sram_din0, {PAR_ON & ^prev_data, prev_data});
            exp_rv = exp_q.size() > 0 && exp_q[0].due == cyc;
            exp_done = m_zdone; exp_par = 0; exp_d = '0; b.last = 0;
            if (exp_rv) begin
                b = exp_q.pop_front();
                exp_d = b.d; exp_done = exp_done | b.last; exp_par = PAR_ON & b.par;
            end
            check("rd_rvalid", bus.rd_rvalid, exp_rv);
            if (exp_rv) check("rd_rdata", bus.rd_rdata, exp_d);
            check("rd_done", bus.rd_done, exp_done);
            check("par_err", bus.par_err, exp_par);
            check("rd_busy", bus.rd_busy, m_busy);
            rd_pend = m_left > 0 && !after_rst;
            exp_wr = bus.wr_valid && !after_rst && (!rd_pend || m_rr_wr);
            rd_g = rd_pend && !exp_wr;
            check("wr_ready", bus.wr_ready, exp_wr);
            if (rd_pend && bus.wr_valid) m_rr_wr = !m_rr_wr;
            prev_g = exp_wr ? 1 : rd_g ? 2 : 0;
            if (exp_wr) begin
                ref_mem[bus.wr_addr] = bus.wr_data;
                prev_addr = bus.wr_addr; prev_data = bus.wr_data;
            end
            if (rd_g) begin
                exp_q.push_back('{cyc + 3, ref_mem[m_addr[AW-1:0]], m_left == 1, flip});
                prev_addr = m_addr[AW-1:0];
                m_addr = (m_addr + 1) % 128;
                m_left--;
            end
            m_zdone = !m_busy && bus.rd_start && bus.rd_len == 0;
            if (!m_busy && bus.rd_start && bus.rd_len != 0) begin
                m_busy = 1;
                m_left = (bus.rd_len > 128) ? 128 : int'(bus.rd_len);
                m_addr = int'(bus.rd_base);
            end
            if (exp_rv && b.last) m_busy = 0;
            after_rst = 0; prev_rst = 0;
        end
        cyc++;
        @(posedge clk0);
        #1;
    endtask

    task automatic burst(input logic [AW-1:0] base, input logic [LW-1:0] len,
                         output int beats, output int lat, output logic [DW-1:0] d0, output bit par);
        int s = cyc;
        bit seen = 0;
        bus.rd_start = 1; bus.rd_base = base; bus.rd_len = len;
        step();
        bus.rd_start = 0;
        beats = 0; lat = -1; d0 = '0; par = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            if (o_rv) begin
                if (beats == 0) d0 = o_rdata;
                beats++;
                par |= o_par;
            end
            if (o_done) begin seen = 1; lat = o_cyc - s; end
        end
        check("burst_done_seen", seen, 1);
    endtask

    initial begin
        vec_t vecs[6];
        int beats, lat, n_rv;
        logic [DW-1:0] d0;
        bit par, seen;
        vecs[0] = '{"wr_then_rd5", 1, 5, 32'hDEADBEEF, 0, 5, 1, 1, 4, 32'hDEADBEEF};
        vecs[1] = '{"wrap126", 1, 126, 32'h12345678, 0, 126, 4, 4, 7, 32'h12345678};
        vecs[2] = '{"contend", 0, 100, 32'hA5A5A5A5, 1, 20, 4, 4, 11, 32'h0};
        vecs[3] = '{"zero_len", 0, 0, 32'h0, 0, 10, 0, 0, 1, 32'h0};
        vecs[4] = '{"clamp200", 0, 0, 32'h0, 0, 7, 200, 128, 131, 32'h0};
        vecs[5] = '{"clamp129", 0, 0, 32'h0, 0, 90, 129, 128, 131, 32'h0};
        bus.wr_valid = 1; bus.wr_addr = 3; bus.wr_data = 32'h0BADF00D;
        bus.rd_start = 0; bus.rd_base = 0; bus.rd_len = 0;
        repeat (3) step();
        rst0 = 0;
        step();
        bus.wr_valid = 0;
        step();
        foreach (vecs[i]) begin
            if (vecs[i].wr_first) begin
                bus.wr_valid = 1; bus.wr_addr = vecs[i].waddr; bus.wr_data = vecs[i].wdata;
                step();
            end
            bus.wr_valid = vecs[i].wr_hold; bus.wr_addr = vecs[i].waddr; bus.wr_data = vecs[i].wdata;
            burst(vecs[i].base, vecs[i].len, beats, lat, d0, par);
            check($sformatf("%s_beats", vecs[i].name), beats, vecs[i].beats);
            check($sformatf("%s_latency", vecs[i].name), lat, vecs[i].lat);
            if (vecs[i].beats > 0) check($sformatf("%s_first_data", vecs[i].name), d0, vecs[i].d0);
            bus.wr_valid = 0;
            repeat (2) step();
        end
        // reset one cycle after the second beat of a len-8 burst
        bus.rd_start = 1; bus.rd_base = 40; bus.rd_len = 8;
        step();
        bus.rd_start = 0;
        repeat (2) step();
        n_rv = 0; seen = 0;
        for (int k = 0; k < 14; k++) begin
            rst0 = k < 2;
            step();
            n_rv += int'(o_rv);
            seen |= o_done;
        end
        check("abort_rvalids", n_rv, 0);
        check("abort_done", seen, 0);
        // spare-bit parity write and corrupted readback
        bus.wr_valid = 1; bus.wr_addr = 9; bus.wr_data = 32'h1;
        step();
        bus.wr_valid = 0;
        step();
        check("parity_din_msb", o_din[DW], PAR_ON);
        check("parity_spare_wen", o_spare, PAR_ON);
        flip = 1;
        burst(9, 1, beats, lat, d0, par);
        flip = 0;
        check("parity_flip_data", d0, 32'h1);
        check("parity_flip_err", par, PAR_ON);
        repeat (2) step();
        for (int k = 0; k < 3000; k++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_addr = AW'($urandom_range(120, 135));
            bus.wr_data = $urandom;
            bus.rd_start = $urandom_range(0, 7) == 0;
            bus.rd_base = AW'($urandom_range(120, 135));
            bus.rd_len = ($urandom_range(0, 15) == 0) ? LW'($urandom_range(129, 255)) : LW'($urandom_range(0, 6));
            step();
        end
        bus.wr_valid = 0; bus.rd_start = 0;
        for (int k = 0; k < 300 && (m_busy || exp_q.size() > 0); k++) step();
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", bus.rd_busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
